// File: rtl/aes_dec_pkg.sv
// Shared types and GF(2^8) helpers for the AES decryption datapath.
// Field polynomial is x^8+x^4+x^3+x+1, so a carry out of bit 7 folds back as 8'h1b.
package aes_dec_pkg;

    localparam int AES_COLS = 4;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // The inverse coefficients all share the x^3 term, so each product is built from
    // the same xtime chain with a few XORs.
    function automatic logic [7:0] gmul09(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gmul0b(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gmul0d(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gmul0e(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

endpackage

// File: rtl/inv_mix_column32.sv
// Combinational InvMixColumns of one 32-bit column; row 0 is the most significant byte.
module inv_mix_column32
    import aes_dec_pkg::*;
(
    input  logic [31:0] col,
    output logic [31:0] res
);

    logic [7:0] a0, a1, a2, a3;

    assign a0 = col[31:24];
    assign a1 = col[23:16];
    assign a2 = col[15:8];
    assign a3 = col[7:0];

    assign res[31:24] = gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3);
    assign res[23:16] = gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3);
    assign res[15:8]  = gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3);
    assign res[7:0]   = gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3);

endmodule

// File: rtl/inv_mix_columns_iter.sv
// Iterative AES InvMixColumns, COLS_PER_CYCLE columns per clock, valid/ready on both sides.
// Define INVMIX_ARK_EN to fuse AddRoundKey (in_state ^ round_key) ahead of the transform.
module inv_mix_columns_iter
    import aes_dec_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
`ifdef INVMIX_ARK_EN
    input  logic [127:0] round_key,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cfg
            $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST_CNT = 2'(AES_COLS - COLS_PER_CYCLE);

    state_t       state;
    logic [1:0]   col_cnt;
    logic [127:0] src_reg;
    logic [127:0] src_next;
    logic [31:0]  src_cols [AES_COLS];
    logic [31:0]  out_cols [AES_COLS];
    logic [1:0]   col_idx  [COLS_PER_CYCLE];
    logic [31:0]  col_in   [COLS_PER_CYCLE];
    logic [31:0]  col_res  [COLS_PER_CYCLE];

`ifdef INVMIX_ARK_EN
    assign src_next = in_state ^ round_key;
`else
    assign src_next = in_state;
`endif

    always_comb begin
        for (int i = 0; i < AES_COLS; i++) begin
            src_cols[i] = src_reg[127 - 32*i -: 32];
        end
    end

    assign out_state = {out_cols[0], out_cols[1], out_cols[2], out_cols[3]};

    // Lane k handles column col_cnt+k; the 2-bit sum wraps, which never matters
    // because col_cnt only takes multiples of COLS_PER_CYCLE.
    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_lane
        assign col_idx[k] = col_cnt + 2'(k);
        assign col_in[k]  = src_cols[col_idx[k]];

        inv_mix_column32 u_col (
            .col (col_in[k]),
            .res (col_res[k])
        );
    end

    // NOTE: all state here updates with non-blocking assignments so every register
    // samples the pre-edge values; blocking would let later lines see new values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            col_cnt   <= '0;
            src_reg   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            // NOTE: the result columns are only four registers and out_state must read
            // zero after reset, so they are cleared here unlike a true memory would be.
            for (int i = 0; i < AES_COLS; i++) begin
                out_cols[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        src_reg  <= src_next;
                        col_cnt  <= '0;
                        state    <= CALC;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                CALC: begin
                    for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                        out_cols[col_idx[k]] <= col_res[k];
                    end
                    col_cnt <= col_cnt + CNT_STEP;
                    if (col_cnt == LAST_CNT) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    // Returning to IDLE only re-opens in_ready; acceptance waits a cycle.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_mix_columns_iter.sv
// Self-checking bench for inv_mix_columns_iter: GF(2^8) reference model, directed vectors, random round trips.
module tb_inv_mix_columns_iter;

    localparam int C = 1;
    localparam int N = 4 / C;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [127:0] round_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic         busy;

    int checks   = 0;
    int failures = 0;
    logic [127:0] exp_q [$];

    inv_mix_columns_iter #(.COLS_PER_CYCLE(C)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
`ifdef INVMIX_ARK_EN
        .round_key (round_key),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Shift-and-add multiply in GF(2^8).
    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] p;
        logic       hi;
        a = a_in;
        b = b_in;
        p = '0;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            hi = a[7];
            a  = a << 1;
            if (hi) a = a ^ 8'h1b;
            b  = b >> 1;
        end
        return p;
    endfunction

    // Circulant matrix multiply of every column; inverse=1 uses (0e,0b,0d,09), else (02,03,01,01).
    function automatic logic [127:0] mix_state(input logic [127:0] s, input bit inverse);
        logic [7:0]   coef [4];
        logic [7:0]   a    [4];
        logic [7:0]   acc;
        logic [127:0] r;
        if (inverse) begin
            coef[0] = 8'h0e; coef[1] = 8'h0b; coef[2] = 8'h0d; coef[3] = 8'h09;
        end else begin
            coef[0] = 8'h02; coef[1] = 8'h03; coef[2] = 8'h01; coef[3] = 8'h01;
        end
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++) acc = acc ^ gf_mul(coef[(j - row + 4) % 4], a[j]);
                r[127 - 32*c - 8*row -: 8] = acc;
            end
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single compare process: whenever out_valid is up, out_state must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_valid_unexpected", {127'b0, out_valid}, 128'd0);
            end else begin
                check("out_state", out_state, exp_q[0]);
                check("in_ready_in_done", {127'b0, in_ready}, 128'd0);
                check("busy_in_done", {127'b0, busy}, 128'd1);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic send(input logic [127:0] st, input logic [127:0] key, input int hold, input bit bp);
        int           lat;
        int           waited;
        logic [127:0] eff;
        logic [127:0] held;
        waited = 0;
        while (!in_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", {127'b0, in_ready}, 128'd1);
            return;
        end
`ifdef INVMIX_ARK_EN
        eff = st ^ key;
`else
        eff = st;
`endif
        exp_q.push_back(mix_state(eff, 1'b1));
        in_state  = st;
        round_key = key;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        in_state  = 128'($urandom());
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("latency", 128'(lat), 128'(N));
        held = out_state;
        for (int i = 0; i < hold; i++) begin
            if (bp) begin
                in_valid = 1'b1;
                in_state = {$urandom(), $urandom(), $urandom(), $urandom()};
            end
            tick();
            if (bp) begin
                check("bp_out_valid", {127'b0, out_valid}, 128'd1);
                check("bp_in_ready", {127'b0, in_ready}, 128'd0);
                check("bp_stable", out_state, held);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        if (bp) begin
            check("bp_release_in_ready", {127'b0, in_ready}, 128'd1);
            check("bp_release_busy", {127'b0, busy}, 128'd0);
            tick();
            check("bp_no_spurious_accept", {127'b0, busy}, 128'd0);
        end
    endtask

    localparam logic [127:0] VEC1_IN  = 128'h8e4da1bc_9fdc589d_01010101_d5d5d7d6;
    localparam logic [127:0] VEC1_OUT = 128'hdb135345_f20a225c_01010101_d4d4d4d5;

    initial begin
        logic [127:0] v;
        logic [127:0] k;
        logic [127:0] orig;
        int           rst_ticks;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_state  = '0;
        round_key = '0;
        tick();
        tick();
        check("reset_out_valid", {127'b0, out_valid}, 128'd0);
        check("reset_out_state", out_state, 128'd0);
        check("reset_in_ready", {127'b0, in_ready}, 128'd1);
        check("reset_busy", {127'b0, busy}, 128'd0);
        rst = 1'b0;
        tick();

        // Pin the model with known vectors.
        check("model_vec1", mix_state(VEC1_IN, 1'b1), VEC1_OUT);
        check("model_vec1_fwd", mix_state(VEC1_OUT, 1'b0), VEC1_IN);
        v = {4{32'hc6c6c6c6}};
        check("model_c6", mix_state(v, 1'b1), v);
        v = {32'h4d7ebdf8, {3{32'hc6c6c6c6}}};
        k = mix_state(v, 1'b1);
        check("model_4d7ebdf8", {96'b0, k[127:96]}, {96'b0, 32'h2d26314c});

        send(VEC1_IN, '0, 0, 1'b0);
        send({4{32'hc6c6c6c6}}, '0, 1, 1'b0);
        send({32'hc6c6c6c6, 32'h4d7ebdf8, 32'h4d7ebdf8, 32'hc6c6c6c6}, '0, 0, 1'b0);
        send(VEC1_IN, '0, 10, 1'b1);

        // Reset while the third column is pending.
        rst_ticks = (C == 1) ? 2 : (C == 2) ? 1 : 0;
        in_state  = VEC1_IN;
        in_valid  = 1'b1;
        tick();
        in_valid  = 1'b0;
        repeat (rst_ticks) tick();
        check("pre_reset_busy", {127'b0, busy}, 128'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midop_out_valid", {127'b0, out_valid}, 128'd0);
        check("midop_in_ready", {127'b0, in_ready}, 128'd1);
        check("midop_busy", {127'b0, busy}, 128'd0);
        check("midop_out_state", out_state, 128'd0);
        send(VEC1_IN, '0, 0, 1'b0);

`ifdef INVMIX_ARK_EN
        send(~VEC1_IN, {128{1'b1}}, 0, 1'b0);
`endif

        for (int i = 0; i < 1000; i++) begin
            orig = {$urandom(), $urandom(), $urandom(), $urandom()};
            k    = {$urandom(), $urandom(), $urandom(), $urandom()};
`ifdef INVMIX_ARK_EN
            v = mix_state(orig, 1'b0) ^ k;
`else
            v = mix_state(orig, 1'b0);
`endif
            if (i < 3) check("roundtrip_model", mix_state(mix_state(orig, 1'b0), 1'b1), orig);
            send(v, k, int'($urandom_range(0, 2)), 1'b0);
        end

        tick();
        check("queue_drained", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
